// File: rtl/adder_share_arbiter.sv
// Shares one (WIDTH+1)-bit adder among NREQ requesters with a registered one-hot grant
// and a valid/ready result channel. Define ADDER_ARB_FIXED_PRIO_EN for fixed priority.
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_flat,
    input  logic [NREQ*WIDTH-1:0] b_flat,
    input  logic [NREQ-1:0]       cin,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     w_winner;
    logic               w_found;
    int unsigned        w_idx;
    logic [WIDTH-1:0]   w_a_arr [NREQ];
    logic [WIDTH-1:0]   w_b_arr [NREQ];
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic               r_op_cin;
    logic [NREQ-1:0]    r_gnt;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_sum;
    logic               r_rsp_cout;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign w_a_arr[k] = a_flat[k*WIDTH +: WIDTH];
        assign w_b_arr[k] = b_flat[k*WIDTH +: WIDTH];
    end

    // Search starts at r_ptr and wraps; fixed priority simply keeps r_ptr at 0.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = i + 32'(r_ptr);
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req[IDW'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = IDW'(w_idx);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_CALC;
            S_CALC:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_cin    <= 1'b0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= NREQ'(1) << w_winner;
                        r_op_a   <= w_a_arr[w_winner];
                        r_op_b   <= w_b_arr[w_winner];
                        r_op_cin <= cin[w_winner];
                        r_rsp_id <= w_winner;
                    end
                end
                S_CALC: begin
                    {r_rsp_cout, r_rsp_sum} <= {1'b0, r_op_a} + {1'b0, r_op_b}
                                               + (WIDTH+1)'(r_op_cin);
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
                        r_ptr <= '0;
`else
                        r_ptr <= (r_rsp_id == IDW'(NREQ-1)) ? '0 : r_rsp_id + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized bench for adder_share_arbiter against a transaction-level model
// (arbitration order by rule, sums by plain 64-bit arithmetic).
module tb_adder_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_flat;
    logic [NREQ*WIDTH-1:0] b_flat;
    logic [NREQ-1:0]       cin;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
        .cin(cin), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin from the pointer, or lowest index under fixed priority.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            int k = i;
`else
            int k = (p + i) % NREQ;
`endif
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic raise(input int k, input logic [31:0] a, input logic [31:0] b, input logic c);
        req[k] = 1'b1;
        a_flat[k*WIDTH +: WIDTH] = a;
        b_flat[k*WIDTH +: WIDTH] = b;
        cin[k] = c;
    endtask

    task automatic scramble(input int k);
        a_flat[k*WIDTH +: WIDTH] = $urandom;
        b_flat[k*WIDTH +: WIDTH] = $urandom;
        cin[k] = 1'($urandom % 2);
    endtask

    // Called at a negedge with the DUT idle and req nonzero; ends at the accept negedge.
    task automatic run_txn(input int hold, input bit keep, output int win);
        int ew;
        longint total;
        logic [31:0] es;
        logic ec;
        ew  = pick(req, ptr_m);
        win = ew;
        if (ew < 0) return;
        total = longint'(a_flat[ew*WIDTH +: WIDTH]) + longint'(b_flat[ew*WIDTH +: WIDTH])
                + longint'(cin[ew]);
        es = total[31:0];
        ec = total[32];
        @(negedge clk);
        chk("gnt_onehot", gnt, 64'(1) << ew);
        chk("busy_calc", busy, 1);
        if (!keep) req[ew] = 1'b0;
        scramble(ew);
        @(negedge clk);
        chk("gnt_drop", gnt, 0);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, ew);
        chk("rsp_sum", rsp_sum, es);
        chk("rsp_cout", rsp_cout, ec);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            scramble(ew);
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_sum", rsp_sum, es);
            chk("hold_id", rsp_id, ew);
            chk("hold_gnt", gnt, 0);
            chk("hold_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("accept_valid", rsp_valid, 0);
        chk("accept_busy", busy, 0);
`ifndef ADDER_ARB_FIXED_PRIO_EN
        ptr_m = (ew + 1) % NREQ;
`endif
        rsp_ready = 1'($urandom % 2);
    endtask

    int w;
    int exp_rr [5];
    logic [NREQ-1:0] nr;

    initial begin
        rst_n = 1'b0; req = '0; a_flat = '0; b_flat = '0; cin = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cout", rsp_cout, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        raise(0, 32'd30, 32'd33, 1'b0);
        run_txn(0, 0, w);
        chk("single_id", w, 0);

        raise(1, 32'd25, 32'd26, 1'b1);
        run_txn(1, 0, w);
        raise(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_txn(0, 0, w);
        chk("carry_id", w, 1);

        // Reset while the adder is busy must abort without a response.
        raise(0, 32'h1234, 32'h10, 1'b0);
        @(negedge clk);
        chk("rst_mid_gnt", gnt, 1);
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_gnt0", gnt, 0);
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_resp", rsp_valid, 0);
        end

`ifdef ADDER_ARB_FIXED_PRIO_EN
        exp_rr = '{0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < NREQ; k++) raise(k, $urandom, $urandom, 1'($urandom % 2));
        for (int i = 0; i < 5; i++) begin
            run_txn(0, 1, w);
            chk("rr_order", w, exp_rr[i]);
        end
        req = '0;

        raise(2, $urandom, $urandom, 1'b1);
        run_txn(5, 0, w);
        chk("bp_id", w, 2);

        raise(0, $urandom, $urandom, 1'b0);
        raise(3, $urandom, $urandom, 1'b1);
        run_txn(0, 0, w);
`ifdef ADDER_ARB_FIXED_PRIO_EN
        chk("wrap_first", w, 0);
`else
        chk("wrap_first", w, 3);
`endif
        run_txn(2, 0, w);
`ifdef ADDER_ARB_FIXED_PRIO_EN
        chk("wrap_second", w, 3);
`else
        chk("wrap_second", w, 0);
`endif

        for (int t = 0; t < 60; t++) begin
            if (req == '0 && (t % 5) == 0) begin
                rsp_ready = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk("idle_valid", rsp_valid, 0);
                    chk("idle_busy", busy, 0);
                end
            end
            nr = NREQ'($urandom);
            if ((req | nr) == '0) nr[$urandom % NREQ] = 1'b1;
            for (int k = 0; k < NREQ; k++) begin
                if (nr[k] && !req[k]) begin
                    if ($urandom % 8 == 0) raise(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
                    else raise(k, $urandom, $urandom, 1'($urandom % 2));
                end
            end
            run_txn(int'($urandom % 4), 0, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
